button_conditioner: RTL and testbench

Front-end conditioning stage for the car's physical controls, placed directly upstream of the top-level power/driving state machine. It synchronises and debounces the raw power button and the six manual-driving buttons. It classifies power-button presses as long (≥ hold time, power-on request) or short (power-off request). It delivers clean levels plus one-cycle edge pulses to the state machine and the UART command byte.

---
 rtl/button_pkg.sv | 21 ++
 rtl/debounce_cell.sv | 48 ++++
 rtl/button_conditioner.sv | 134 +++++++++++++
 tb/tb_button_conditioner.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared constants for the button conditioning front end: default timing,
// power FSM encoding and bit positions of the manual-driving buttons.
package button_pkg;

    localparam int TICK_CYCLES_DEF    = 100_000;
    localparam int DEBOUNCE_TICKS_DEF = 20;
    localparam int HOLD_TICKS_DEF     = 1000;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_PRESSED = 2'b01;
    localparam logic [1:0] ST_LONG    = 2'b10;

    localparam int NUM_MOVE     = 6;
    localparam int BTN_FORWARD  = 0;
    localparam int BTN_BACKWARD = 1;
    localparam int BTN_LEFT     = 2;
    localparam int BTN_RIGHT    = 3;
    localparam int BTN_PLACE    = 4;
    localparam int BTN_DESTROY  = 5;

endpackage

// File: rtl/debounce_cell.sv
// One debounced input: two-flop synchroniser, tick-based persistence counter
// and the accepted (stable) level register.
module debounce_cell
    import button_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_raw,
    output logic level
);

    localparam int CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic             meta_reg;
    logic             sync_reg;
    logic             stable_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg   <= 1'b0;
            sync_reg   <= 1'b0;
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            meta_reg <= btn_raw;
            sync_reg <= meta_reg;
            // Any return to the accepted level restarts the persistence count.
            if (sync_reg == stable_reg) begin
                cnt_reg <= '0;
            end else if (tick) begin
                if (cnt_reg == CNT_LAST) begin
                    stable_reg <= sync_reg;
                    cnt_reg    <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    assign level = stable_reg;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the power and movement buttons: shared tick prescaler, seven
// debounce cells, rise detectors and the long/short power-press classifier.
module button_conditioner
    import button_pkg::*;
#(
    parameter int TICK_CYCLES    = TICK_CYCLES_DEF,
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
    parameter int HOLD_TICKS     = HOLD_TICKS_DEF
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic                power_btn_raw,
    input  logic [NUM_MOVE-1:0] move_btn_raw,
    output logic                power_level,
    output logic                power_on_1sec,
    output logic                power_off_pulse,
    output logic [NUM_MOVE-1:0] move_level,
    output logic [NUM_MOVE-1:0] move_rise
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

    logic [PW-1:0]       presc_reg;
    logic                tick;
    logic                pl;
    logic [NUM_MOVE-1:0] move_stable;
    logic [NUM_MOVE-1:0] stable_d_reg;
    logic [NUM_MOVE-1:0] move_rise_reg;
    logic [1:0]          state_reg;
    logic [HW-1:0]       hold_reg;
    logic [HW-1:0]       hold_next;
    logic                power_on_reg;
    logic                power_off_reg;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
        end else if (presc_reg == PRESC_LAST) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PW'(1);
        end
    end

    assign tick = (presc_reg == PRESC_LAST);

    debounce_cell #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_power_cell (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .btn_raw (power_btn_raw),
        .level   (pl)
    );

    generate
        for (genvar gi = 0; gi < NUM_MOVE; gi++) begin : g_move
            debounce_cell #(
                .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
            ) u_move_cell (
                .sys_clk (sys_clk),
                .rst_n   (rst_n),
                .tick    (tick),
                .btn_raw (move_btn_raw[gi]),
                .level   (move_stable[gi])
            );
        end
    endgenerate

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_d_reg  <= '0;
            move_rise_reg <= '0;
        end else begin
            stable_d_reg  <= move_stable;
            move_rise_reg <= move_stable & ~stable_d_reg;
        end
    end

    // Saturating increment keeps hold meaningful even if the press lingers.
    assign hold_next = (hold_reg == HOLD_MAX) ? hold_reg : hold_reg + HW'(1);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            hold_reg      <= '0;
            power_on_reg  <= 1'b0;
            power_off_reg <= 1'b0;
        end else begin
            power_on_reg  <= 1'b0;
            power_off_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pl) begin
                        hold_reg  <= '0;
                        state_reg <= ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (tick) begin
                        hold_reg <= hold_next;
                    end
                    // Release wins over a long-press tick landing in the same cycle.
                    if (!pl) begin
                        power_off_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end else if (tick && (hold_next == HOLD_MAX)) begin
                        power_on_reg <= 1'b1;
                        state_reg    <= ST_LONG;
                    end
                end
                ST_LONG: begin
                    if (!pl) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign power_level     = pl;
    assign power_on_1sec   = power_on_reg;
    assign power_off_pulse = power_off_reg;
    assign move_level      = move_stable;
    assign move_rise       = move_rise_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: stimulus queues expected output
// events, an independent negedge monitor pops and compares them.
module tb_button_conditioner;

    localparam int TC = 4;
    localparam int DT = 3;
    localparam int HT = 10;

    localparam int K_PL  = 0;
    localparam int K_ON  = 1;
    localparam int K_OFF = 2;
    localparam int K_ML  = 3;
    localparam int K_MR  = 4;

    logic       sys_clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       power_btn_raw = 1'b0;
    logic [5:0] move_btn_raw = 6'b0;
    logic       power_level;
    logic       power_on_1sec;
    logic       power_off_pulse;
    logic [5:0] move_level;
    logic [5:0] move_rise;

    button_conditioner #(
        .TICK_CYCLES    (TC),
        .DEBOUNCE_TICKS (DT),
        .HOLD_TICKS     (HT)
    ) dut (
        .sys_clk         (sys_clk),
        .rst_n           (rst_n),
        .power_btn_raw   (power_btn_raw),
        .move_btn_raw    (move_btn_raw),
        .power_level     (power_level),
        .power_on_1sec   (power_on_1sec),
        .power_off_pulse (power_off_pulse),
        .move_level      (move_level),
        .move_rise       (move_rise)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int         kind;
        logic [5:0] val;
    } ev_t;

    ev_t        exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         pl_rise_cyc = 0;
    bit         mon_en = 1'b0;
    logic       prev_pl = 1'b0;
    logic [5:0] prev_ml = 6'b0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_PL:    return "power_level";
            K_ON:    return "power_on_1sec";
            K_OFF:   return "power_off_pulse";
            K_ML:    return "move_level";
            K_MR:    return "move_rise";
            default: return "unknown";
        endcase
    endfunction

    task automatic push(input int kind, input logic [5:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic mon_event(input int kind, input logic [5:0] val);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got %s=%0h at cycle %0d, expected no event", kname(kind), val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val) begin
                n_bad++;
                $display("FAIL event_order: got %s=%0h at cycle %0d, expected %s=%0h",
                         kname(kind), val, cyc, kname(e.kind), e.val);
            end else begin
                $display("ok   event %s=%0h at cycle %0d", kname(kind), val, cyc);
            end
        end
    endtask

    always @(negedge sys_clk) begin
        if (mon_en) begin
            if (power_level !== prev_pl) begin
                mon_event(K_PL, {5'b0, power_level});
                if (power_level === 1'b1) pl_rise_cyc = cyc;
            end
            if (power_on_1sec === 1'b1) begin
                mon_event(K_ON, 6'b0);
                n_cmp++;
                if ((cyc - pl_rise_cyc) < (HT - 1) * TC || (cyc - pl_rise_cyc) > HT * TC + 2) begin
                    n_bad++;
                    $display("FAIL on_delay: got %0d cycles after power_level rise, expected %0d..%0d",
                             cyc - pl_rise_cyc, (HT - 1) * TC, HT * TC + 2);
                end else begin
                    $display("ok   on_delay: %0d cycles", cyc - pl_rise_cyc);
                end
            end
            if (power_off_pulse === 1'b1) mon_event(K_OFF, 6'b0);
            if (move_level !== prev_ml) mon_event(K_ML, move_level);
            if (move_rise !== 6'b0) mon_event(K_MR, move_rise);
            prev_pl = power_level;
            prev_ml = move_level;
        end
    end

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge sys_clk);
            #1;
            n++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s: got %0d events still pending (next %s=%0h), expected 0",
                     name, exp_q.size(), kname(exp_q[0].kind), exp_q[0].val);
            exp_q.delete();
        end else begin
            $display("ok   %s: all expected events seen", name);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_power_level"}, {31'b0, power_level}, 32'd0);
        check({tag, "_power_on"}, {31'b0, power_on_1sec}, 32'd0);
        check({tag, "_power_off"}, {31'b0, power_off_pulse}, 32'd0);
        check({tag, "_move_level"}, {26'b0, move_level}, 32'd0);
        check({tag, "_move_rise"}, {26'b0, move_rise}, 32'd0);
    endtask

    task automatic wait_power_level(input string name, input int lo, input int hi);
        int n;
        n = 0;
        while (power_level !== 1'b1 && n < 25) begin
            @(negedge sys_clk);
            n++;
        end
        check(name, {31'b0, (n >= lo && n <= hi)}, 32'd1);
    endtask

    initial begin
        // Test 1: reset with every move button held.
        #2;
        rst_n = 1'b0;
        move_btn_raw = 6'b111111;
        repeat (5) @(negedge sys_clk);
        #1;
        check_all_zero("t1_reset");
        mon_en = 1'b1;
        push(K_ML, 6'b111111);
        push(K_MR, 6'b111111);
        @(negedge sys_clk);
        rst_n = 1'b1;
        begin
            int n;
            n = 0;
            while (move_level !== 6'b111111 && n < 25) begin
                @(negedge sys_clk);
                n++;
            end
            check("t1_level_latency_le15", {31'b0, (n <= 2 + 4 * DT + 1)}, 32'd1);
        end
        drain("t1_rise", 10);
        push(K_ML, 6'b000000);
        move_btn_raw = 6'b000000;
        drain("t1_release", 40);

        // Test 2: power glitch of two ticks is rejected.
        @(negedge sys_clk);
        power_btn_raw = 1'b1;
        repeat (2 * TC) @(negedge sys_clk);
        power_btn_raw = 1'b0;
        repeat (40) @(negedge sys_clk);
        #1;
        check("t2_power_level", {31'b0, power_level}, 32'd0);
        drain("t2_no_events", 1);

        // Test 3: short press gives exactly one power_off_pulse.
        push(K_PL, 6'd1);
        power_btn_raw = 1'b1;
        wait_power_level("t3_rise_latency", 1, 2 + 4 * DT + 1);
        repeat (5 * TC) @(negedge sys_clk);
        push(K_PL, 6'd0);
        push(K_OFF, 6'd0);
        power_btn_raw = 1'b0;
        drain("t3_short", 40);

        // Test 4: long press gives one power_on_1sec and a silent release.
        push(K_PL, 6'd1);
        push(K_ON, 6'd0);
        power_btn_raw = 1'b1;
        wait_power_level("t4_rise_latency", 1, 2 + 4 * DT + 1);
        repeat (20 * TC) @(negedge sys_clk);
        drain("t4_long", 1);
        push(K_PL, 6'd0);
        power_btn_raw = 1'b0;
        repeat (40) @(negedge sys_clk);
        drain("t4_release", 10);

        // Test 5: bit 2 bounces for 40 cycles, then settles high.
        for (int i = 0; i < 20; i++) begin
            move_btn_raw[2] = ~move_btn_raw[2];
            repeat (2) @(negedge sys_clk);
        end
        #1;
        check("t5_no_early_level", {26'b0, move_level}, 32'd0);
        push(K_ML, 6'b000100);
        push(K_MR, 6'b000100);
        move_btn_raw = 6'b000100;
        drain("t5_settle", 40);
        push(K_ML, 6'b000000);
        move_btn_raw = 6'b000000;
        drain("t5_release", 40);

        // Test 6: reset mid-press, button still held afterwards.
        push(K_PL, 6'd1);
        power_btn_raw = 1'b1;
        wait_power_level("t6_rise_latency", 1, 2 + 4 * DT + 1);
        repeat (6 * TC + 2) @(negedge sys_clk);
        push(K_PL, 6'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_async_reset");
        repeat (3) @(negedge sys_clk);
        push(K_PL, 6'd1);
        push(K_ON, 6'd0);
        rst_n = 1'b1;
        wait_power_level("t6_redebounce_latency", 2 + 4 * (DT - 1), 2 + 4 * DT + 1);
        repeat (12 * TC) @(negedge sys_clk);
        drain("t6_fresh_long", 10);
        push(K_PL, 6'd0);
        power_btn_raw = 1'b0;
        drain("t6_release", 40);
        repeat (10) @(negedge sys_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule
